tow_bot_player: RTL

- Automated opponent for the tug-of-war game. It drives a pushbutton line in place of a human player, as pbl or pbr.
- It watches the round-start indication that the master controller already uses to light the LEDs (leds_on). After a pseudo-random, skill-scaled reaction delay, it produces a clean press pulse.
- It runs on the 500 Hz game clock from clk_div. Its pb output feeds the existing push-button sync/decision path unchanged.

---
 rtl/tow_pkg.sv | 25 ++
 rtl/tow_lfsr8.sv | 30 +++
 rtl/tow_bot_player.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tow_pkg.sv
// ---------------------------------------------------------------------------
// tow_pkg
// Shared definitions for the tug-of-war bot player and its LFSR.
//   state_t            : bot FSM states
//   LFSR_TAPS          : feedback mask for x^8+x^6+x^5+x^4+1
//   DEFAULT_MIN_DELAY  : minimum reaction delay in game-clock ticks
//   DEFAULT_PRESS_HOLD : cycles the fake pushbutton is held high
// ---------------------------------------------------------------------------
package tow_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        DELAY = 3'd2,
        PRESS = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bits 7,5,4,3 correspond to taps 8,6,5,4 of the polynomial.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int DEFAULT_MIN_DELAY  = 20;
    localparam int DEFAULT_PRESS_HOLD = 5;

endpackage

// File: rtl/tow_lfsr8.sv
// ---------------------------------------------------------------------------
// tow_lfsr8
// Free-running 8-bit Fibonacci LFSR, advancing every clock.
//   clk   : in  clock
//   rst   : in  asynchronous active-high reset, loads the seed
//   value : out current LFSR state (never zero)
// ---------------------------------------------------------------------------
module tow_lfsr8
    import tow_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5,
    parameter logic [7:0] TAPS = LFSR_TAPS
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [7:0] START = (SEED == 8'h00) ? 8'h01 : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= START;
        end else begin
            value <= {value[6:0], ^(value & TAPS)};
        end
    end

endmodule

// File: rtl/tow_bot_player.sv
// ---------------------------------------------------------------------------
// tow_bot_player
// Automated tug-of-war opponent. Waits for a round start (go rising), then
// after a pseudo-random, skill-scaled delay issues a PRESS_HOLD-cycle pulse
// on pb. Optionally cheats with an occasional false start.
//   clk         : in  500 Hz game clock
//   rst         : in  asynchronous active-high reset
//   en          : in  bot enabled; low forces IDLE
//   go          : in  round-start indication (leds_on)
//   clr         : in  round clear
//   skill       : in  right-shift applied to the random delay part
//   cheat_en    : in  allow false starts
//   pb          : out pushbutton output to the game
//   busy        : out high in DELAY or PRESS
//   press_count : out saturating count of presses issued
// ---------------------------------------------------------------------------
module tow_bot_player
    import tow_pkg::*;
#(
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         MIN_DELAY  = DEFAULT_MIN_DELAY,
    parameter int         RAND_BITS  = 6,
    parameter int         PRESS_HOLD = DEFAULT_PRESS_HOLD,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             go,
    input  logic             clr,
    input  logic [1:0]       skill,
    input  logic             cheat_en,
    output logic             pb,
    output logic             busy,
    output logic [CNT_W-1:0] press_count
);

    // Wide enough for MIN_DELAY plus the largest random part.
    localparam int DELAY_W = $clog2(MIN_DELAY + (1 << RAND_BITS));
    localparam int HOLD_W  = $clog2(PRESS_HOLD + 1);

    state_t               state;
    logic [7:0]           lfsr;
    logic                 go_d;
    logic                 go_rise;
    logic                 false_start;
    logic [RAND_BITS-1:0] rand_part;
    logic [DELAY_W-1:0]   delay_load;
    logic [DELAY_W-1:0]   delay_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 lfsr_unused;

    tow_lfsr8 #(
        .SEED (SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    // Only the low LFSR bits feed the delay and cheat decisions.
    assign lfsr_unused = ^lfsr;

    // Round-start edge, reaction delay to load, and cheat condition.
    always_comb begin
        go_rise     = go & ~go_d;
        rand_part   = lfsr[RAND_BITS-1:0] >> skill;
        delay_load  = DELAY_W'(MIN_DELAY) + DELAY_W'(rand_part);
        false_start = cheat_en & ~go & (lfsr[3:0] == 4'd0);
    end

    // Bot FSM with registered pb/busy. A false start leaves ARM, so each
    // ARM entry can produce at most one. The press counter is bumped on
    // every entry into PRESS, whichever way it was reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pb          <= 1'b0;
            busy        <= 1'b0;
            press_count <= '0;
            delay_cnt   <= '0;
            hold_cnt    <= '0;
            go_d        <= 1'b0;
        end else begin
            go_d <= go;
            if (!en) begin
                state <= IDLE;
                pb    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        pb    <= 1'b0;
                        busy  <= 1'b0;
                    end
                    ARM: begin
                        if (clr) begin
                            state <= ARM;
                        end else if (go_rise) begin
                            delay_cnt <= delay_load;
                            state     <= DELAY;
                            busy      <= 1'b1;
                        end else if (false_start) begin
                            state    <= PRESS;
                            pb       <= 1'b1;
                            busy     <= 1'b1;
                            hold_cnt <= HOLD_W'(PRESS_HOLD);
                            if (press_count != '1) begin
                                press_count <= press_count + CNT_W'(1);
                            end
                        end
                    end
                    DELAY: begin
                        if (clr || !go) begin
                            state <= ARM;
                            busy  <= 1'b0;
                        end else if (delay_cnt == DELAY_W'(1)) begin
                            state    <= PRESS;
                            pb       <= 1'b1;
                            busy     <= 1'b1;
                            hold_cnt <= HOLD_W'(PRESS_HOLD);
                            if (press_count != '1) begin
                                press_count <= press_count + CNT_W'(1);
                            end
                        end else begin
                            delay_cnt <= delay_cnt - DELAY_W'(1);
                        end
                    end
                    PRESS: begin
                        if (clr) begin
                            state <= ARM;
                            pb    <= 1'b0;
                            busy  <= 1'b0;
                        end else if (hold_cnt == HOLD_W'(1)) begin
                            state <= DONE;
                            pb    <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    DONE: begin
                        if (clr || !go) begin
                            state <= ARM;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        pb    <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
